// File: rtl/lbp_stream.sv
// Streaming 3x3 local-binary-pattern engine: reads a raster image once and emits one LBP code per interior pixel.
// Optional LBP_BORDER_WRITE_EN: zero-fill all border result addresses before the image is read.
module lbp_stream #(
    parameter int unsigned IMG_W = 128,
    parameter int unsigned IMG_H = 128,
    parameter int unsigned AW    = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gray_ready,
    output logic          gray_req,
    output logic [AW-1:0] gray_addr,
    input  logic [7:0]    gray_data,
    output logic          lbp_valid,
    output logic [AW-1:0] lbp_addr,
    output logic [7:0]    lbp_data,
    output logic          finish
);

    localparam int unsigned CW    = $clog2(IMG_W);
    localparam int unsigned RW    = $clog2(IMG_H);
    localparam int unsigned TOTAL = IMG_W * IMG_H;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                   state_q, state_n;
    logic [RW-1:0]            row_q, row_n;
    logic [CW-1:0]            col_q, col_n;
    logic [AW-1:0]            addr_n;
    logic [2:0][2:0][7:0]     win_q, win_n, win_sh;
    logic                     valid_n;
    logic [AW-1:0]            laddr_n;
    logic [7:0]               ldata_n;
    logic                     finish_n;
    logic [7:0]               code_c;
    logic [7:0]               ctr_c;
    logic                     sample_c;
    logic                     interior_c;
    logic                     last_c;
    logic [7:0]               lb0 [IMG_W];
    logic [7:0]               lb1 [IMG_W];
`ifdef LBP_BORDER_WRITE_EN
    logic [AW-1:0]            clr_addr_q, clr_addr_n;
    logic                     clr_done_q, clr_done_n;
    logic                     edge_row_c;

    assign edge_row_c = (row_q == '0) || (row_q == RW'(IMG_H - 1));
`endif

    // A pixel is consumed on every READ cycle the source is ready.
    assign sample_c   = (state_q == S_READ) && gray_ready;
    assign gray_req   = sample_c;
    assign interior_c = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign last_c     = (gray_addr == AW'(TOTAL - 1));

    // Window after shifting in the incoming column (rows r-2, r-1, r).
    always_comb begin
        win_sh = win_q;
        for (int r = 0; r < 3; r++) begin
            win_sh[r][0] = win_q[r][1];
            win_sh[r][1] = win_q[r][2];
        end
        win_sh[0][2] = lb1[col_q];
        win_sh[1][2] = lb0[col_q];
        win_sh[2][2] = gray_data;
    end

    assign ctr_c  = win_sh[1][1];
    assign code_c = {win_sh[2][2] >= ctr_c, win_sh[2][1] >= ctr_c, win_sh[2][0] >= ctr_c,
                     win_sh[1][2] >= ctr_c, win_sh[1][0] >= ctr_c,
                     win_sh[0][2] >= ctr_c, win_sh[0][1] >= ctr_c, win_sh[0][0] >= ctr_c};

    // Next-state and registered-output logic.
    always_comb begin
        state_n  = state_q;
        row_n    = row_q;
        col_n    = col_q;
        addr_n   = gray_addr;
        win_n    = win_q;
        valid_n  = 1'b0;
        laddr_n  = lbp_addr;
        ldata_n  = lbp_data;
        finish_n = finish;
`ifdef LBP_BORDER_WRITE_EN
        clr_addr_n = clr_addr_q;
        clr_done_n = clr_done_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (gray_ready) begin
`ifdef LBP_BORDER_WRITE_EN
                    state_n = S_CLEAR;
`else
                    state_n = S_READ;
`endif
                end
            end
`ifdef LBP_BORDER_WRITE_EN
            // Walk border addresses in ascending order; the extra idle cycle keeps the last write clear of gray_req.
            S_CLEAR: begin
                if (clr_done_q) begin
                    state_n    = S_READ;
                    row_n      = '0;
                    col_n      = '0;
                    clr_done_n = 1'b0;
                end else begin
                    valid_n = 1'b1;
                    laddr_n = clr_addr_q;
                    ldata_n = '0;
                    if (col_q == CW'(IMG_W - 1)) begin
                        if (row_q == RW'(IMG_H - 1)) begin
                            clr_done_n = 1'b1;
                        end else begin
                            row_n      = row_q + RW'(1);
                            col_n      = '0;
                            clr_addr_n = clr_addr_q + AW'(1);
                        end
                    end else if (edge_row_c) begin
                        col_n      = col_q + CW'(1);
                        clr_addr_n = clr_addr_q + AW'(1);
                    end else begin
                        col_n      = CW'(IMG_W - 1);
                        clr_addr_n = clr_addr_q + AW'(IMG_W - 1);
                    end
                end
            end
`endif
            S_READ: begin
                if (gray_ready) begin
                    win_n = win_sh;
                    if (interior_c) begin
                        valid_n = 1'b1;
                        laddr_n = gray_addr - AW'(IMG_W + 1);
                        ldata_n = code_c;
                    end
                    if (last_c) begin
                        state_n = S_DRAIN;
                    end else begin
                        addr_n = gray_addr + AW'(1);
                        if (col_q == CW'(IMG_W - 1)) begin
                            col_n = '0;
                            row_n = row_q + RW'(1);
                        end else begin
                            col_n = col_q + CW'(1);
                        end
                    end
                end
            end
            S_DRAIN: begin
                state_n  = S_DONE;
                finish_n = 1'b1;
            end
            S_DONE: begin
                state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            gray_addr <= '0;
            win_q     <= '0;
            lbp_valid <= 1'b0;
            lbp_addr  <= '0;
            lbp_data  <= '0;
            finish    <= 1'b0;
`ifdef LBP_BORDER_WRITE_EN
            clr_addr_q <= '0;
            clr_done_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            row_q     <= row_n;
            col_q     <= col_n;
            gray_addr <= addr_n;
            win_q     <= win_n;
            lbp_valid <= valid_n;
            lbp_addr  <= laddr_n;
            lbp_data  <= ldata_n;
            finish    <= finish_n;
`ifdef LBP_BORDER_WRITE_EN
            clr_addr_q <= clr_addr_n;
            clr_done_q <= clr_done_n;
`endif
        end
    end

    // Line buffers: row r-1 in lb0, row r-2 in lb1; only rows written this frame ever reach an output.
    always_ff @(posedge clk) begin
        if (sample_c) begin
            lb1[col_q] <= lb0[col_q];
            lb0[col_q] <= gray_data;
        end
    end

endmodule

// File: tb/tb_lbp_stream.sv
// Directed bench for lbp_stream on a 5x4 image: ramp, constant, reference vector, stall and mid-frame reset.
module tb_lbp_stream;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int AW = 5;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          reset;
    logic          gray_ready;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic [7:0]    gray_data;
    logic          lbp_valid;
    logic [AW-1:0] lbp_addr;
    logic [7:0]    lbp_data;
    logic          finish;

    always #5 clk = ~clk;

    lbp_stream #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish)
    );

    logic [7:0] img [32];
    assign gray_data = img[gray_addr];

    int         checks = 0;
    int         passed = 0;
    int         cyc = 0;
    int         s12;
    int         fv6;
    int         wr_total;
    int         fin_rises;
    int         wr_cnt [32];
    logic [7:0] wr_dat [32];
    logic       fin_d;
    logic       clr_mon = 1'b0;

    // Cycle counter and the cycle in which address 12 is sampled.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr_mon) s12 <= -1;
        else if (gray_req && gray_addr == 5'd12 && s12 < 0) s12 <= cyc;
    end

    // Result sink: writes land on the falling edge.
    always @(negedge clk) begin
        fin_d <= finish;
        if (clr_mon) begin
            for (int i = 0; i < 32; i++) begin
                wr_cnt[i] <= 0;
                wr_dat[i] <= 8'h00;
            end
            wr_total  <= 0;
            fv6       <= -1;
            fin_rises <= 0;
        end else begin
            if (lbp_valid) begin
                wr_cnt[lbp_addr] <= wr_cnt[lbp_addr] + 1;
                wr_dat[lbp_addr] <= lbp_data;
                wr_total         <= wr_total + 1;
                if (lbp_addr == 5'd6 && fv6 < 0) fv6 <= cyc;
            end
            if (finish && !fin_d) fin_rises <= fin_rises + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        @(negedge clk);
        clr_mon = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr_mon = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b0;
        gray_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_frame(input string tag);
        bit done;
        done       = 1'b0;
        gray_ready = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (finish) done = 1'b1;
        end
        chk({tag, "_finish_seen"}, 32'(done), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Every interior address written once with code, borders per build option.
    task automatic check_uniform(input string tag, input logic [7:0] code);
        int r;
        int c;
        bit inner;
        for (int a = 0; a < N; a++) begin
            r     = a / W;
            c     = a % W;
            inner = (r >= 1 && r <= H - 2 && c >= 1 && c <= W - 2);
            if (inner) begin
                chk($sformatf("%s_cnt%0d", tag, a), 32'(wr_cnt[a]), 32'd1);
                chk($sformatf("%s_code%0d", tag, a), 32'(wr_dat[a]), 32'(code));
            end else begin
`ifdef LBP_BORDER_WRITE_EN
                chk($sformatf("%s_bcnt%0d", tag, a), 32'(wr_cnt[a]), 32'd1);
                chk($sformatf("%s_bcode%0d", tag, a), 32'(wr_dat[a]), 32'd0);
`else
                chk($sformatf("%s_bcnt%0d", tag, a), 32'(wr_cnt[a]), 32'd0);
`endif
            end
        end
`ifdef LBP_BORDER_WRITE_EN
        chk({tag, "_total"}, 32'(wr_total), 32'd20);
`else
        chk({tag, "_total"}, 32'(wr_total), 32'd6);
`endif
        chk({tag, "_fin_once"}, 32'(fin_rises), 32'd1);
    endtask

    initial begin
        reset      = 1'b0;
        gray_ready = 1'b0;
        for (int i = 0; i < 32; i++) img[i] = 8'h00;
        repeat (3) @(negedge clk);

        chk("rst_gray_req", 32'(gray_req), 32'd0);
        chk("rst_gray_addr", 32'(gray_addr), 32'd0);
        chk("rst_lbp_valid", 32'(lbp_valid), 32'd0);
        chk("rst_lbp_addr", 32'(lbp_addr), 32'd0);
        chk("rst_lbp_data", 32'(lbp_data), 32'd0);
        chk("rst_finish", 32'(finish), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_gray_req", 32'(gray_req), 32'd0);

        // Ramp image: every interior code is 0xF0.
        for (int i = 0; i < N; i++) img[i] = 8'(i);
        clear_mon();
        run_frame("ramp");
        check_uniform("ramp", 8'hF0);
        chk("ramp_s12_seen", 32'(s12 >= 0), 32'd1);
        chk("ramp_latency", 32'(fv6), 32'(s12 + 1));
        chk("done_gray_req", 32'(gray_req), 32'd0);
        chk("done_lbp_valid", 32'(lbp_valid), 32'd0);
        chk("done_finish", 32'(finish), 32'd1);

        // Constant image: all neighbours equal the centre.
        do_reset();
        for (int i = 0; i < N; i++) img[i] = 8'h55;
        clear_mon();
        run_frame("const");
        check_uniform("const", 8'hFF);

        // Reference neighbourhood around address 7.
        do_reset();
        for (int i = 0; i < N; i++) img[i] = 8'h00;
        img[7]  = 8'h80;
        img[1]  = 8'h7F;
        img[2]  = 8'h80;
        img[3]  = 8'h81;
        img[6]  = 8'h00;
        img[8]  = 8'hFF;
        img[11] = 8'h10;
        img[12] = 8'h80;
        img[13] = 8'h90;
        clear_mon();
        run_frame("vec");
        chk("vec_code7", 32'(wr_dat[7]), 32'hD6);
        chk("vec_cnt7", 32'(wr_cnt[7]), 32'd1);

        // Source stall of 7 cycles mid-row.
        do_reset();
        for (int i = 0; i < N; i++) img[i] = 8'(i);
        clear_mon();
        gray_ready = 1'b1;
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 200 && !hit; i++) begin
                @(negedge clk);
                if (gray_addr == 5'd13) hit = 1'b1;
            end
            chk("stall_reach13", 32'(hit), 32'd1);
        end
        gray_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("stall_addr_%0d", i), 32'(gray_addr), 32'd13);
            chk($sformatf("stall_req_%0d", i), 32'(gray_req), 32'd0);
            chk($sformatf("stall_valid_%0d", i), 32'(lbp_valid), 32'd0);
        end
        run_frame("stall");
        check_uniform("stall", 8'hF0);

        // Reset mid-frame, then a full clean rerun.
        do_reset();
        for (int i = 0; i < N; i++) img[i] = 8'(i);
        gray_ready = 1'b1;
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 200 && !hit; i++) begin
                @(negedge clk);
                if (gray_addr == 5'd10) hit = 1'b1;
            end
            chk("abort_reach10", 32'(hit), 32'd1);
        end
        reset      = 1'b0;
        gray_ready = 1'b0;
        #1;
        chk("abort_gray_req", 32'(gray_req), 32'd0);
        chk("abort_gray_addr", 32'(gray_addr), 32'd0);
        chk("abort_lbp_valid", 32'(lbp_valid), 32'd0);
        chk("abort_lbp_addr", 32'(lbp_addr), 32'd0);
        chk("abort_lbp_data", 32'(lbp_data), 32'd0);
        chk("abort_finish", 32'(finish), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_mon();
        chk("rerun_start_addr", 32'(gray_addr), 32'd0);
        run_frame("rerun");
        check_uniform("rerun", 8'hF0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
